// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter and IDLE/ACCESS/DONE sequencer for the unified memory port
// shared by the multicycle core and the loader/debug port.
module mem_port_arbiter #(
  parameter int WIDTH   = 32,
  parameter int TIMEOUT = 255
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             core_req,
  input  logic             core_we,
  input  logic [WIDTH-1:0] core_addr,
  input  logic [WIDTH-1:0] core_wdata,
  output logic [WIDTH-1:0] core_rdata,
  output logic             core_ack,
  output logic             core_err,
  output logic             stall,
  input  logic             ldr_req,
  input  logic             ldr_we,
  input  logic [WIDTH-1:0] ldr_addr,
  input  logic [WIDTH-1:0] ldr_wdata,
  output logic [WIDTH-1:0] ldr_rdata,
  output logic             ldr_ack,
  output logic             ldr_err,
  output logic             mem_req,
  output logic             mem_we,
  output logic [WIDTH-1:0] mem_addr,
  output logic [WIDTH-1:0] mem_wdata,
  input  logic [WIDTH-1:0] mem_rdata,
  input  logic             mem_ready,
  output logic             busy
);

  typedef enum logic [1:0] {IDLE, ACCESS, DONE} stateType;

  localparam logic [7:0] WD_LAST = 8'(TIMEOUT - 1);

  stateType         stateReg, stateNext;
  logic             winnerReg, winnerNext;       // 1 = loader, 0 = core
  logic             lastGrantReg, lastGrantNext;
  logic             errReg, errNext;
  logic [7:0]       wdReg, wdNext;
  logic             weReg, weNext;
  logic [WIDTH-1:0] addrReg, addrNext;
  logic [WIDTH-1:0] wdataReg, wdataNext;
  logic [WIDTH-1:0] coreRdataReg, coreRdataNext;
  logic [WIDTH-1:0] ldrRdataReg, ldrRdataNext;
  logic             grantLdr;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stateReg     <= IDLE;
      winnerReg    <= 1'b0;
      lastGrantReg <= 1'b1;
      errReg       <= 1'b0;
      wdReg        <= '0;
      weReg        <= 1'b0;
      addrReg      <= '0;
      wdataReg     <= '0;
      coreRdataReg <= '0;
      ldrRdataReg  <= '0;
    end else begin
      stateReg     <= stateNext;
      winnerReg    <= winnerNext;
      lastGrantReg <= lastGrantNext;
      errReg       <= errNext;
      wdReg        <= wdNext;
      weReg        <= weNext;
      addrReg      <= addrNext;
      wdataReg     <= wdataNext;
      coreRdataReg <= coreRdataNext;
      ldrRdataReg  <= ldrRdataNext;
    end
  end

  always_comb begin
    stateNext     = stateReg;
    winnerNext    = winnerReg;
    lastGrantNext = lastGrantReg;
    errNext       = errReg;
    wdNext        = wdReg;
    weNext        = weReg;
    addrNext      = addrReg;
    wdataNext     = wdataReg;
    coreRdataNext = coreRdataReg;
    ldrRdataNext  = ldrRdataReg;
    // On a tie the loader wins only if the core was served last.
    grantLdr      = ldr_req & (~core_req | ~lastGrantReg);

    case (stateReg)
      IDLE: begin
        if (core_req || ldr_req) begin
          winnerNext = grantLdr;
          weNext     = grantLdr ? ldr_we    : core_we;
          addrNext   = grantLdr ? ldr_addr  : core_addr;
          wdataNext  = grantLdr ? ldr_wdata : core_wdata;
          wdNext     = '0;
          errNext    = 1'b0;
          stateNext  = ACCESS;
        end
      end
      ACCESS: begin
        if (mem_ready) begin
          if (!weReg) begin
            if (winnerReg) ldrRdataNext  = mem_rdata;
            else           coreRdataNext = mem_rdata;
          end
          errNext   = 1'b0;
          stateNext = DONE;
        end else if (wdReg == WD_LAST) begin
          // Hung access: a timed-out read returns zero, a write leaves rdata alone.
          if (!weReg) begin
            if (winnerReg) ldrRdataNext  = '0;
            else           coreRdataNext = '0;
          end
          errNext   = 1'b1;
          stateNext = DONE;
        end else begin
          wdNext = wdReg + 8'd1;
        end
      end
      DONE: begin
        lastGrantNext = winnerReg;
        stateNext     = IDLE;
      end
      default: stateNext = IDLE;
    endcase
  end

  assign mem_req    = (stateReg == ACCESS);
  assign mem_we     = weReg & mem_req;
  assign mem_addr   = addrReg;
  assign mem_wdata  = wdataReg;
  assign busy       = (stateReg != IDLE);
  assign core_ack   = (stateReg == DONE) & ~winnerReg;
  assign ldr_ack    = (stateReg == DONE) &  winnerReg;
  assign core_err   = core_ack & errReg;
  assign ldr_err    = ldr_ack & errReg;
  assign core_rdata = coreRdataReg;
  assign ldr_rdata  = ldrRdataReg;
  assign stall      = core_req & ~core_ack;

endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Sequencer and arbiter for the single unified memory port of the multicycle MIPS core. It shares one memory between two requesters: the core's IorD-muxed memory path and the program loader/debug port. It serializes their accesses through a three-phase state machine, handles a variable-latency memory via a ready handshake, and aborts hung accesses with a watchdog. It also gives the multicycle control FSM a stall signal so the FSM holds its memory state until the access completes.

## Interface
Parameters:
- WIDTH, 32, data and address width
- TIMEOUT, 255, maximum ACCESS cycles before abort; legal range 1..255

Ports:
- clk  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-low reset
- core_req  in  1  core access request; level, held until core_ack
- core_we  in  1  core write (1) / read (0)
- core_addr  in  WIDTH  core byte address
- core_wdata  in  WIDTH  core write data
- core_rdata  out  WIDTH  registered read data for the core
- core_ack  out  1  one-cycle completion pulse to the core
- core_err  out  1  pulses with core_ack when the access timed out
- stall  out  1  to control FSM; equals core_req & ~core_ack (combinational)
- ldr_req, ldr_we, ldr_addr, ldr_wdata, ldr_rdata, ldr_ack, ldr_err  same directions, widths and meanings as the core_* set, for the loader port
- mem_req  out  1  memory request; held high for the whole ACCESS phase
- mem_we  out  1  memory write enable, valid while mem_req is high
- mem_addr  out  WIDTH  latched address
- mem_wdata  out  WIDTH  latched write data
- mem_rdata  in  WIDTH  memory read data; valid when mem_ready is high
- mem_ready  in  1  memory completion; sampled only in ACCESS
- busy  out  1  high in ACCESS and DONE

## Operation
- States: IDLE, ACCESS, DONE. Reset state is IDLE.
- IDLE, no request: stay in IDLE.
- IDLE, one request: grant it, latch we/addr/wdata, clear the watchdog, go to ACCESS.
- IDLE, both requesting: round-robin. Grant the port not granted last. last_grant resets to loader, so the core wins the first tie.
- ACCESS: mem_req=1 and mem_we/mem_addr/mem_wdata are driven from the latched values. Requester inputs are ignored, even if they change.
- ACCESS, mem_ready=1: on a read, capture mem_rdata into the winner's rdata register. Go to DONE with err=0.
- ACCESS, mem_ready=0: the watchdog increments. If the watchdog reaches TIMEOUT-1 with mem_ready still low, go to DONE with err=1 and load the winner's rdata with 0.
- Watchdog vs. ready: mem_ready in the final allowed cycle wins; that access completes normally.
- DONE: pulse the winner's ack for one cycle, plus err if set. Update last_grant. Return to IDLE. Requests are not sampled in DONE.
- Writes leave the rdata registers unchanged. The non-granted port's rdata, ack and err are never disturbed.
- Requester rule: drop req in the cycle after ack unless it wants another access. A req still high in IDLE starts a new access.
- mem_ready outside ACCESS is ignored.

## Timing
- Reset (asynchronous, while reset=0): state=IDLE and all outputs are 0: mem_req, mem_we, mem_addr, mem_wdata, both rdata, both ack, both err, busy. Also last_grant=loader and watchdog=0.
- stall reflects core_req directly, including during reset.
- Reset mid-access: the access is abandoned and no ack is issued after release. The first request after release is served normally.
- Request sampled at edge N: mem_req is high from cycle N+1.
- mem_ready high in the first ACCESS cycle: ack in cycle N+2, and rdata is valid in the same cycle.
- Minimum occupancy is 3 cycles per access. Back-to-back requests from one port complete every 3 cycles.
- Latency = 2 + (cycles mem_ready stays low), capped at a total of TIMEOUT+1.
- mem_* outputs are stable for the entire ACCESS phase. mem_req drops in DONE.

## Test plan
- Core read: core_req, core_addr=0x40; mem_ready rises 2 cycles after mem_req; mem_rdata=0xDEADBEEF -> mem_addr=0x40 and mem_we=0 for 3 cycles; core_ack for 1 cycle with core_rdata=0xDEADBEEF; stall high from req until ack.
- Tie after reset, mem_ready tied high: both ports request repeatedly -> grant order core, loader, core, loader; one ack every 3 cycles.
- Loader write: ldr_we=1, ldr_addr=0x100, ldr_wdata=0x12345678 -> mem_we=1 with those values; ldr_ack pulses; core_rdata and ldr_rdata unchanged.
- Timeout: TIMEOUT=4, mem_ready held 0 on a core read -> mem_req high for exactly 4 cycles; then core_ack with core_err=1 and core_rdata=0. With mem_ready=1 in the 4th cycle instead -> normal ack, err=0.
- Reset in ACCESS: assert reset in the 2nd ACCESS cycle -> all outputs 0 immediately; no ack after release; the next core read completes normally with its data.
- Input change during ACCESS: alter core_addr mid-access -> mem_addr holds the latched address until DONE.
